// File: rtl/btn_debounce_core.sv
// btn_debounce_core
//   MMIO slot core that synchronises and debounces N_BTN raw push-buttons
//   and latches sticky press flags. Firmware reads the flags and clears them
//   with write-one-to-clear.
//
//   Register map (addr[1:0] decoded, addr[4:2] ignored):
//     0 R    debounced levels
//     1 R    press flags         W1C clears
//     2 RW   debounce threshold  (0 behaves as 1)
//     3 R    release flags       W1C clears   (only with BTN_RELEASE_EDGE_EN)
//
//   Optional feature macro: BTN_RELEASE_EDGE_EN
//     defined     -> sticky release flags at address 3
//     not defined -> address 3 reads 0 and ignores writes
module btn_debounce_core #(
    parameter int N_BTN    = 5,
    parameter int DB_TICKS = 500_000,
    parameter int THR_W    = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cs,
    input  logic             read,
    input  logic             write,
    input  logic [4:0]       addr,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data,
    input  logic [N_BTN-1:0] btn
);

    typedef enum logic [1:0] {
        REG_DB  = 2'd0,
        REG_PRS = 2'd1,
        REG_THR = 2'd2,
        REG_REL = 2'd3
    } reg_addr_e;

    localparam logic [THR_W-1:0] THR_RST = THR_W'(DB_TICKS);
    localparam logic [THR_W-1:0] THR_ONE = THR_W'(1);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    reg_addr_e reg_sel;
    logic      wr_en;

    assign reg_sel = reg_addr_e'(addr[1:0]);
    assign wr_en   = cs & write;

    // read has no side effects and the upper address bits alias the map.
    logic unused_bus;
    assign unused_bus = &{1'b0, read, addr[4:2], wr_data};

    // ------------------------------------------------------------------
    // Two-flop synchroniser; sync2_q is the metastability-safe sample
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    // Capture the asynchronous buttons through two back-to-back flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let both stages sample the old
            // values on the same edge, which is what makes this a 2-FF chain.
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Threshold register
    // ------------------------------------------------------------------
    logic [THR_W-1:0] thr_q;
    logic [THR_W-1:0] thr_d;
    logic [THR_W-1:0] thr_eff;
    logic [THR_W-1:0] thr_last;

    // A zero threshold would never allow a flip, so it is treated as one.
    assign thr_eff  = (thr_q == '0) ? THR_ONE : thr_q;
    assign thr_last = thr_eff - THR_ONE;

    // Load the threshold from the bus; the new value is used from the next cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned and infers a latch.
        thr_d = thr_q;
        if (wr_en && reg_sel == REG_THR) begin
            thr_d = wr_data[THR_W-1:0];
        end
    end

    // Hold the threshold register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thr_q <= THR_RST;
        end else begin
            thr_q <= thr_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce: the debounced level follows the synchronised
    // sample only after it has disagreed for thr_eff consecutive cycles.
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] db_q;
    logic [N_BTN-1:0] db_d;
    logic [THR_W-1:0] cnt_q [N_BTN];
    logic [THR_W-1:0] cnt_d [N_BTN];

    // Count consecutive mismatch cycles and flip the level when the run completes.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= thr_last) begin
                // ">=" also covers a threshold lowered below a running count.
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + THR_ONE;
            end
        end
    end

    // Hold debounced levels and mismatch counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q <= '0;
            // NOTE: the counter array is real control state, not a storage
            // memory, so it is reset element by element like any register.
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky press flags (set wins over a same-cycle W1C)
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] prs_clr;
    logic [N_BTN-1:0] prs_q;
    logic [N_BTN-1:0] prs_d;

    assign rise    = db_d & ~db_q;
    assign prs_clr = (wr_en && reg_sel == REG_PRS) ? wr_data[N_BTN-1:0] : '0;

    // Clear requested flags first, then OR in new presses so a set always wins.
    always_comb begin
        prs_d = (prs_q & ~prs_clr) | rise;
    end

    // Hold the press flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prs_q <= '0;
        end else begin
            prs_q <= prs_d;
        end
    end

`ifdef BTN_RELEASE_EDGE_EN
    // ------------------------------------------------------------------
    // Sticky release flags (set wins over a same-cycle W1C)
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] rel_clr;
    logic [N_BTN-1:0] rel_q;
    logic [N_BTN-1:0] rel_d;

    assign fall    = db_q & ~db_d;
    assign rel_clr = (wr_en && reg_sel == REG_REL) ? wr_data[N_BTN-1:0] : '0;

    // Clear requested flags first, then OR in new releases.
    always_comb begin
        rel_d = (rel_q & ~rel_clr) | fall;
    end

    // Hold the release flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rel_q <= '0;
        end else begin
            rel_q <= rel_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux: purely combinational from addr, so reset values show
    // through while reset_n is low.
    // ------------------------------------------------------------------

    // Select the register addressed by addr[1:0].
    always_comb begin
        rd_data = '0;
        unique case (reg_sel)
            REG_DB:  rd_data = 32'(db_q);
            REG_PRS: rd_data = 32'(prs_q);
            REG_THR: rd_data = 32'(thr_q);
            REG_REL: begin
`ifdef BTN_RELEASE_EDGE_EN
                rd_data = 32'(rel_q);
`else
                rd_data = '0;
`endif
            end
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_btn_debounce_core.sv
// tb_btn_debounce_core
//   Self-checking bench for btn_debounce_core (N_BTN=5, DB_TICKS=8).
//   A behavioural model tracks, per button, how many consecutive cycles the
//   synchronised input has disagreed with the debounced level; directed
//   scenarios are followed by randomized traffic. Define BTN_RELEASE_EDGE_EN
//   for both RTL and bench to cover the release-flag build.
`timescale 1ns/1ps
module tb_btn_debounce_core;

    localparam int N      = 5;
    localparam int TICKS  = 8;
    localparam int TW     = 20;

    logic        clk;
    logic        reset_n;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [N-1:0] btn;

    btn_debounce_core #(
        .N_BTN    (N),
        .DB_TICKS (TICKS),
        .THR_W    (TW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .btn     (btn)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    //   hist[0] = btn sampled on the last edge, hist[1] = the one before;
    //   the debouncer sees hist[1] (two-edge synchroniser delay).
    //   run[i] = consecutive cycles the seen value disagreed with db.
    // ------------------------------------------------------------------
    logic [N-1:0]  hist [2];
    logic [N-1:0]  m_db;
    logic [N-1:0]  m_prs;
    logic [N-1:0]  m_rel;
    logic [TW-1:0] m_thr;
    int            run [N];

    task automatic model_reset();
        hist[0] = '0;
        hist[1] = '0;
        m_db    = '0;
        m_prs   = '0;
        m_rel   = '0;
        m_thr   = TW'(TICKS);
        for (int i = 0; i < N; i++) run[i] = 0;
    endtask

    // One rising edge, using the inputs currently driven.
    task automatic model_edge();
        int           need;
        logic [N-1:0] seen;
        logic [N-1:0] new_db;
        logic [N-1:0] clr;
        need   = (m_thr == 0) ? 1 : int'(m_thr);
        seen   = hist[1];
        new_db = m_db;
        for (int i = 0; i < N; i++) begin
            if (seen[i] == m_db[i]) begin
                run[i] = 0;
            end else begin
                run[i] = run[i] + 1;
                if (run[i] >= need) begin
                    new_db[i] = seen[i];
                    run[i]    = 0;
                end
            end
        end
        clr   = (cs && write && addr[1:0] == 2'd1) ? wr_data[N-1:0] : '0;
        m_prs = (m_prs & ~clr) | (new_db & ~m_db);
`ifdef BTN_RELEASE_EDGE_EN
        clr   = (cs && write && addr[1:0] == 2'd3) ? wr_data[N-1:0] : '0;
        m_rel = (m_rel & ~clr) | (m_db & ~new_db);
`endif
        if (cs && write && addr[1:0] == 2'd2) m_thr = wr_data[TW-1:0];
        m_db    = new_db;
        hist[1] = hist[0];
        hist[0] = btn;
    endtask

    function automatic logic [31:0] model_rd(input int a);
        case (a)
            0:       return 32'(m_db);
            1:       return 32'(m_prs);
            2:       return 32'(m_thr);
            default: return 32'(m_rel);
        endcase
    endfunction

    // Read all four registers (with random alias bits) against the model.
    task automatic cmp_all();
        logic [2:0] hi;
        for (int a = 0; a < 4; a++) begin
            hi   = 3'($urandom_range(0, 7));
            addr = {hi, 2'(a)};
            #1;
            check($sformatf("reg%0d", a), rd_data, model_rd(a));
        end
    endtask

    task automatic rd_reg(input int a, output logic [31:0] v);
        addr = 5'(a);
        #1;
        v = rd_data;
    endtask

    // One clock cycle: drive at negedge, model the posedge, compare after it.
    task automatic cyc(input logic [N-1:0] b, input logic c, input logic w,
                       input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        btn     = b;
        cs      = c;
        write   = w;
        read    = 1'($urandom_range(0, 1));
        addr    = a;
        wr_data = d;
        @(posedge clk);
        model_edge();
        #1;
        cs    = 1'b0;
        write = 1'b0;
        cmp_all();
    endtask

    // Assert reset mid-cycle, check reset values, release after one edge.
    task automatic apply_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        cmp_all();
        @(posedge clk);
        #5;
        reset_n = 1'b1;
    endtask

    logic [31:0]  v;
    logic [N-1:0] rb;

    initial begin
        reset_n = 1'b0;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        wr_data = '0;
        btn     = '0;
        model_reset();
        @(posedge clk);
        #5;
        reset_n = 1'b1;

        // 1: reset mid-count restores threshold and restarts counting.
        cyc(5'h00, 1'b1, 1'b1, 5'd2, 32'd5);
        for (int k = 0; k < 5; k++) cyc(5'h01, 1'b0, 1'b0, 5'd0, 32'd0);
        apply_reset();
        rd_reg(0, v); check("t1_db_after_rst", v, 32'h0);
        rd_reg(1, v); check("t1_prs_after_rst", v, 32'h0);
        rd_reg(2, v); check("t1_thr_after_rst", v, 32'd8);
        for (int k = 0; k < 9; k++) cyc(5'h01, 1'b0, 1'b0, 5'd0, 32'd0);
        rd_reg(0, v); check("t1_db_edge9", v, 32'h0);
        cyc(5'h01, 1'b0, 1'b0, 5'd0, 32'd0);
        rd_reg(0, v); check("t1_db_edge10", v, 32'h1);

        // 2: clean press, exact 10-edge latency, then W1C.
        apply_reset();
        for (int k = 0; k < 9; k++) cyc(5'h01, 1'b0, 1'b0, 5'd0, 32'd0);
        rd_reg(0, v); check("t2_db_edge9", v, 32'h0);
        cyc(5'h01, 1'b0, 1'b0, 5'd0, 32'd0);
        rd_reg(0, v); check("t2_db_edge10", v, 32'h1);
        rd_reg(1, v); check("t2_prs_set", v, 32'h1);
        cyc(5'h01, 1'b1, 1'b1, 5'd1, 32'h1);
        rd_reg(1, v); check("t2_prs_w1c", v, 32'h0);

        // 3: pulses one cycle too short never get through.
        apply_reset();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 8; k++) begin
                cyc((k < 7) ? 5'h04 : 5'h00, 1'b0, 1'b0, 5'd0, 32'd0);
                rd_reg(0, v); check("t3_db_glitch", v, 32'h0);
            end
        end
        rd_reg(1, v); check("t3_prs_glitch", v, 32'h0);

        // 4: threshold 0 behaves as 1 -> three edges of latency.
        apply_reset();
        cyc(5'h00, 1'b1, 1'b1, 5'd2, 32'd0);
        rd_reg(2, v); check("t4_thr_zero", v, 32'h0);
        for (int k = 0; k < 2; k++) begin
            cyc(5'h10, 1'b0, 1'b0, 5'd0, 32'd0);
            rd_reg(0, v); check("t4_db_early", v, 32'h0);
        end
        cyc(5'h10, 1'b0, 1'b0, 5'd0, 32'd0);
        rd_reg(0, v); check("t4_db_edge3", v, 32'h10);

        // 5: W1C on the very edge the press is detected -> set wins.
        apply_reset();
        for (int k = 0; k < 9; k++) cyc(5'h02, 1'b0, 1'b0, 5'd0, 32'd0);
        rd_reg(0, v); check("t5_db_edge9", v, 32'h0);
        cyc(5'h02, 1'b1, 1'b1, 5'd1, 32'h2);
        rd_reg(0, v); check("t5_db_edge10", v, 32'h2);
        rd_reg(1, v); check("t5_prs_set_wins", v, 32'h2);

        // 6: release flag (or zero without the feature); writes to 0 ignored.
        apply_reset();
        for (int k = 0; k < 10; k++) cyc(5'h08, 1'b0, 1'b0, 5'd0, 32'd0);
        cyc(5'h08, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        rd_reg(0, v); check("t6_db_pressed", v, 32'h8);
        for (int k = 0; k < 10; k++) cyc(5'h00, 1'b0, 1'b0, 5'd0, 32'd0);
        rd_reg(0, v); check("t6_db_released", v, 32'h0);
        rd_reg(3, v);
`ifdef BTN_RELEASE_EDGE_EN
        check("t6_rel", v, 32'h8);
`else
        check("t6_rel", v, 32'h0);
`endif

        // Randomized traffic: toggling buttons, threshold changes, W1C, aliased addresses.
        apply_reset();
        rb = '0;
        for (int n = 0; n < 3000; n++) begin
            logic        c;
            logic        w;
            logic [4:0]  a;
            logic [31:0] d;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
            end
            c = ($urandom_range(0, 3) == 0);
            w = 1'($urandom_range(0, 1));
            a = 5'($urandom);
            d = (a[1:0] == 2'd2) ? 32'($urandom_range(0, 6)) : $urandom;
            if ($urandom_range(0, 999) == 0) apply_reset();
            cyc(rb, c, w, a, d);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
